calc_entry_sequencer: RTL
=========================

// Module: calc_entry_sequencer
// PURPOSE
//  Sequences keyboard entries into one calculator transaction:
//  - operand A -> operator -> operand B -> ALU request -> result display.
//  Sits between keyboard_top and the ALU/display path.
//  Drives op_ctrl back to the keyboard so each key is interpreted as a number or an operator.
//  Owns the req/ack handshake to the ALU. Supports chaining the result as the next operand A.
// PARAMETERS
//  DATA_W          8          operand/result width (binary, unsigned)
//  OP_W            4          operator code width
//  TIMEOUT_CYCLES  1_000_000  max cycles in S_REQ waiting for alu_ack (10 ms @ 100 MHz)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  kb_valid    in   1       1-cycle pulse: kb_data holds a new number/operator
//  kb_data     in   DATA_W  number (op_ctrl=0) or operator in [OP_W-1:0] (op_ctrl=1)
//  kb_enter    in   1       1-cycle pulse: enter key rising edge
//  clr         in   1       level/pulse: abort and return to S_NUM_A
//  alu_ack     in   1       ALU accepted request; alu_result valid this cycle
//  alu_result  in   DATA_W  ALU result, sampled only when alu_req && alu_ack
//  op_ctrl     out  1       1 = keyboard interprets keys as operators
//  operand_a   out  DATA_W  registered operand A
//  operand_b   out  DATA_W  registered operand B
//  alu_op      out  OP_W    registered operator code
//  alu_req     out  1       request to ALU; held high until ack/timeout/clr
//  disp_value  out  DATA_W  value to display (current operand or result)
//  busy        out  1       high in S_REQ
//  err         out  1       sticky: ALU timeout; cleared on leaving S_SHOW or on clr
//  bad_key     out  1       1-cycle pulse: illegal operator code rejected
//  state_o     out  3       current state (debug / seg_en control)
// BEHAVIOUR
//  Reset:
//  - state=S_NUM_A; all outputs 0; internal has_a/has_b flags 0; timeout counter 0.
//  Legal operators: 4'hA add, 4'hB sub, 4'hC mul, 4'hD div. Any other code is illegal.
//  clr has top priority in every state:
//  - next state S_NUM_A; alu_req=0 next cycle, with no wait for ack.
//  - Operands, operator, err and flags clear to 0.
//  S_NUM_A (op_ctrl=0, disp=operand_a):
//  - kb_valid: operand_a<=kb_data, has_a<=1; the last entry wins.
//  - kb_enter with has_a, or with kb_valid in the same cycle: -> S_OP.
//  - kb_enter with no A: ignored.
//  S_OP (op_ctrl=1, disp=operand_a):
//  - kb_valid with a legal code: alu_op<=kb_data[OP_W-1:0], -> S_NUM_B.
//  - kb_valid with an illegal code: bad_key pulse for 1 cycle; stay.
//  - kb_enter: ignored.
//  S_NUM_B (op_ctrl=0, disp=operand_b):
//  - Same capture rules as S_NUM_A, writing operand_b/has_b.
//  - Enter with B (including same-cycle kb_valid): -> S_REQ.
//  S_REQ (busy=1, alu_req=1):
//  - alu_req is asserted the cycle after entry.
//  - Operands and alu_op are stable while alu_req=1.
//  - alu_ack with alu_req: result<=alu_result; alu_req=0 next cycle; -> S_SHOW.
//  - Keyboard inputs are ignored.
//  - Counter counts cycles with alu_req=1 and no ack.
//  - At TIMEOUT_CYCLES: err<=1, result<=0, alu_req drops, -> S_SHOW.
//  - An ack in the timeout cycle wins; err stays 0.
//  S_SHOW (op_ctrl=0, disp=result):
//  - kb_enter: operand_a<=result, has_a=1, has_b=0, err<=0, -> S_OP (chaining).
//  - kb_valid (no enter): operand_a<=kb_data, has_a=1, has_b=0, err<=0, -> S_NUM_A.
//  - Both in the same cycle: kb_enter wins; kb_valid is dropped.
//  Arithmetic: none in this block; values pass through unchanged, with no width change.
//  op_ctrl, disp_value and alu_req are registered: state-to-output latency is 1 cycle.
// TESTING
//  - Reset, then kb_valid 12, enter, op 4'hA, kb_valid 30, enter -> alu_req=1, operand_a=12, operand_b=30, alu_op=A.
//  - Same flow, alu_ack after 5 cycles with result 42 -> alu_req low next cycle, S_SHOW, disp_value=42, err=0.
//  - In S_OP, kb_data=4'h3 -> bad_key 1-cycle pulse, state stays S_OP; then 4'hB -> S_NUM_B.
//  - In S_REQ, no ack for TIMEOUT_CYCLES (set to 16) -> err=1, alu_req=0, disp_value=0; ack at cycle 16 -> err=0.
//  - In S_SHOW with result 42, kb_enter -> S_OP, operand_a=42; kb_valid+kb_enter same cycle -> enter wins.
//  - clr while alu_req=1, then rst mid-S_NUM_B -> S_NUM_A, all outputs 0 next cycle; enter without data ignored.

Source files
------------

// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: gathers operand A, an operator and operand B from the keyboard,
// issues one ALU request, shows the result and can chain that result as the next operand A.
module calc_entry_sequencer #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned OP_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kb_valid,
  input  logic [DATA_W-1:0] kb_data,
  input  logic              kb_enter,
  input  logic              clr,
  input  logic              alu_ack,
  input  logic [DATA_W-1:0] alu_result,
  output logic              op_ctrl,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_req,
  output logic [DATA_W-1:0] disp_value,
  output logic              busy,
  output logic              err,
  output logic              bad_key,
  output logic [2:0]        state_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StNumA = 3'd0,
    StOp   = 3'd1,
    StNumB = 3'd2,
    StReq  = 3'd3,
    StShow = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   operand_a_q, operand_a_d;
  logic [DATA_W-1:0]   operand_b_q, operand_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                has_a_q, has_a_d;
  logic                has_b_q, has_b_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                op_ctrl_q, op_ctrl_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                alu_req_q, alu_req_d;
  logic                bad_key_q, bad_key_d;

  logic [OP_W-1:0]     key_op;
  logic                legal_op;
  logic                ack_hit;
  logic                timeout_hit;

  assign key_op   = kb_data[OP_W-1:0];
  assign legal_op = (key_op == OP_W'(4'hA)) || (key_op == OP_W'(4'hB)) ||
                    (key_op == OP_W'(4'hC)) || (key_op == OP_W'(4'hD));
  // An ack only counts while the request is actually visible to the ALU.
  assign ack_hit     = alu_req_q && alu_ack;
  // This is the TIMEOUT_CYCLES-th requested cycle without an ack; an ack here wins.
  assign timeout_hit = alu_req_q && !alu_ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StNumA;
      operand_a_q <= '0;
      operand_b_q <= '0;
      alu_op_q    <= '0;
      result_q    <= '0;
      has_a_q     <= 1'b0;
      has_b_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      op_ctrl_q   <= 1'b0;
      disp_q      <= '0;
      alu_req_q   <= 1'b0;
      bad_key_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      has_a_q     <= has_a_d;
      has_b_q     <= has_b_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      op_ctrl_q   <= op_ctrl_d;
      disp_q      <= disp_d;
      alu_req_q   <= alu_req_d;
      bad_key_q   <= bad_key_d;
    end
  end

  // Next state plus operand/result capture; clr overrides everything.
  always_comb begin
    state_d     = state_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    alu_op_d    = alu_op_q;
    result_d    = result_q;
    has_a_d     = has_a_q;
    has_b_d     = has_b_q;
    err_d       = err_q;
    cnt_d       = '0;
    if (clr) begin
      state_d     = StNumA;
      operand_a_d = '0;
      operand_b_d = '0;
      alu_op_d    = '0;
      result_d    = '0;
      has_a_d     = 1'b0;
      has_b_d     = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        StNumA: begin
          if (kb_valid) begin
            operand_a_d = kb_data;
            has_a_d     = 1'b1;
          end
          if (kb_enter && (has_a_q || kb_valid)) state_d = StOp;
        end
        StOp: begin
          if (kb_valid && legal_op) begin
            alu_op_d = key_op;
            state_d  = StNumB;
          end
        end
        StNumB: begin
          if (kb_valid) begin
            operand_b_d = kb_data;
            has_b_d     = 1'b1;
          end
          if (kb_enter && (has_b_q || kb_valid)) state_d = StReq;
        end
        StReq: begin
          cnt_d = cnt_q;
          if (ack_hit) begin
            result_d = alu_result;
            state_d  = StShow;
            cnt_d    = '0;
          end else if (timeout_hit) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = StShow;
            cnt_d    = '0;
          end else if (alu_req_q) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StShow: begin
          // Enter chains the result; a bare number starts a fresh calculation.
          if (kb_enter) begin
            operand_a_d = result_q;
            has_a_d     = 1'b1;
            has_b_d     = 1'b0;
            err_d       = 1'b0;
            state_d     = StOp;
          end else if (kb_valid) begin
            operand_a_d = kb_data;
            has_a_d     = 1'b1;
            has_b_d     = 1'b0;
            err_d       = 1'b0;
            state_d     = StNumA;
          end
        end
        default: state_d = StNumA;
      endcase
    end
  end

  // Next values of the registered outputs, one cycle behind the state.
  always_comb begin
    op_ctrl_d = 1'b0;
    disp_d    = operand_a_q;
    alu_req_d = 1'b0;
    bad_key_d = 1'b0;
    if (clr) begin
      disp_d = '0;
    end else begin
      case (state_q)
        StNumA: disp_d = operand_a_q;
        StOp: begin
          op_ctrl_d = 1'b1;
          disp_d    = operand_a_q;
          bad_key_d = kb_valid && !legal_op;
        end
        StNumB: disp_d = operand_b_q;
        StReq: begin
          disp_d    = operand_b_q;
          alu_req_d = !(ack_hit || timeout_hit);
        end
        StShow: disp_d = result_q;
        default: disp_d = '0;
      endcase
    end
  end

  assign op_ctrl    = op_ctrl_q;
  assign operand_a  = operand_a_q;
  assign operand_b  = operand_b_q;
  assign alu_op     = alu_op_q;
  assign alu_req    = alu_req_q;
  assign disp_value = disp_q;
  assign busy       = (state_q == StReq);
  assign err        = err_q;
  assign bad_key    = bad_key_q;
  assign state_o    = state_q;

endmodule
